ucomb_scan: RTL and testbench



---
 rtl/ucomb_scan_if.sv | 36 +++
 rtl/ucomb_scan.sv | 111 +++++++++++
 tb/tb_ucomb_scan.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/ucomb_scan_if.sv
// Bundle between the wiring-table scanner, its configuration front-end,
// the ucomb_ref query port and the downstream (pin, code) stream consumer.
interface ucomb_scan_if #(
    parameter int PIN_W  = 4,
    parameter int WIRE_N = 6
);
    logic              start;
    logic [1:0]        sel;
    logic [15:0]       func;
    logic [1:0]        q_sel;
    logic [15:0]       q_func;
    logic [PIN_W-1:0]  q_pin;
    logic [WIRE_N-1:0] q_wpin;
    logic              out_valid;
    logic              out_ready;
    logic [PIN_W-1:0]  out_pin;
    logic [2:0]        out_code;
    logic              busy;
    logic              done;
    logic              err;
    logic [PIN_W-1:0]  count;

    // Environment side: front-end, wiring map and stream sink.
    modport master (
        output start, sel, func, q_wpin, out_ready,
        input  q_sel, q_func, q_pin, out_valid, out_pin, out_code,
               busy, done, err, count
    );

    // Scanner side.
    modport slave (
        input  start, sel, func, q_wpin, out_ready,
        output q_sel, q_func, q_pin, out_valid, out_pin, out_code,
               busy, done, err, count
    );
endinterface

// File: rtl/ucomb_scan.sv
// Walks every pin of the selected universal gate, queries the ucomb_ref
// wiring map and streams each one-hot response back as a 3-bit wire code.
module ucomb_scan #(
    parameter int PIN_W  = 4,
    parameter int WIRE_N = 6
) (
    input logic         clk,
    input logic         rst_n,
    ucomb_scan_if.slave bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] QUERY = 2'd1;
    localparam logic [1:0] EMIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]       state;
    logic [1:0]       q_sel;
    logic [15:0]      q_func;
    logic [PIN_W-1:0] q_pin;
    logic [PIN_W-1:0] out_pin;
    logic [2:0]       out_code;
    logic             err;
    logic [PIN_W-1:0] count;
    logic             multi_hot;

    // Index of the last pin for each gate type (u21, u31, u41, u22).
    function automatic logic [PIN_W-1:0] last_pin(input logic [1:0] s);
        case (s)
            2'b00:   return PIN_W'(3);
            2'b01:   return PIN_W'(5);
            2'b10:   return PIN_W'(9);
            default: return PIN_W'(5);
        endcase
    endfunction

    // One-hot to index; any response with two or more bits set maps to 7.
    function automatic logic [2:0] enc_code(input logic [WIRE_N-1:0] w);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < WIRE_N; i++) begin
            if (w[i]) idx = 3'(i);
        end
        if ((w & (w - 1'b1)) != '0) idx = 3'd7;
        return idx;
    endfunction

    assign multi_hot = (bus.q_wpin & (bus.q_wpin - 1'b1)) != '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            q_sel    <= '0;
            q_func   <= '0;
            q_pin    <= '0;
            out_pin  <= '0;
            out_code <= '0;
            err      <= 1'b0;
            count    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        q_sel  <= bus.sel;
                        q_func <= bus.func;
                        q_pin  <= '0;
                        count  <= '0;
                        err    <= 1'b0;
                        state  <= QUERY;
                    end
                end
                QUERY: begin
                    // An all-zero response means the func/pin is not wired: end quietly.
                    if (bus.q_wpin == '0) begin
                        state <= DONE;
                    end else begin
                        out_code <= enc_code(bus.q_wpin);
                        out_pin  <= q_pin;
                        if (multi_hot) err <= 1'b1;
                        state <= EMIT;
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        count <= count + 1'b1;
                        if (q_pin == last_pin(q_sel)) begin
                            state <= DONE;
                        end else begin
                            q_pin <= q_pin + 1'b1;
                            state <= QUERY;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.q_sel     = q_sel;
    assign bus.q_func    = q_func;
    assign bus.q_pin     = q_pin;
    assign bus.out_pin   = out_pin;
    assign bus.out_code  = out_code;
    assign bus.err       = err;
    assign bus.count     = count;
    assign bus.out_valid = (state == EMIT);
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);

endmodule

// File: tb/tb_ucomb_scan.sv
// Directed bench for ucomb_scan with a behavioural stand-in for the ucomb_ref map.
module tb_ucomb_scan;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int   n_chk  = 0;
    int   n_pass = 0;
    logic inject_multi = 1'b0;

    int         n_ent, n_valid, done_cyc, poke_cyc;
    logic [3:0] ent_pin  [16];
    logic [2:0] ent_code [16];
    logic       err_c1;

    ucomb_scan_if #(.PIN_W(4), .WIRE_N(6)) bus ();

    ucomb_scan #(.PIN_W(4), .WIRE_N(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Stand-in wiring map: u21 with high func bits is invalid, 0x1234 wires
    // everything to wire 0, otherwise pin p goes to wire (func[3:0]+p) mod 6.
    function automatic logic [5:0] ref_model(input logic [1:0] s, input logic [15:0] f,
                                             input logic [3:0] p);
        if (s == 2'b00 && f[15:4] != 12'h000) return 6'b000000;
        if (f == 16'h1234) return 6'b000001;
        return 6'b000001 << ((int'(f[3:0]) + int'(p)) % 6);
    endfunction

    always_comb begin
        if (inject_multi && bus.q_pin == 4'd2) bus.q_wpin = 6'b000011;
        else bus.q_wpin = ref_model(bus.q_sel, bus.q_func, bus.q_pin);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(bus.out_valid), 0);
        check({tag, "_busy"},  32'(bus.busy), 0);
        check({tag, "_done"},  32'(bus.done), 0);
        check({tag, "_err"},   32'(bus.err), 0);
        check({tag, "_count"}, 32'(bus.count), 0);
        check({tag, "_qpin"},  32'(bus.q_pin), 0);
        check({tag, "_qsel"},  32'(bus.q_sel), 0);
        check({tag, "_qfunc"}, 32'(bus.q_func), 0);
        check({tag, "_opin"},  32'(bus.out_pin), 0);
        check({tag, "_ocode"}, 32'(bus.out_code), 0);
    endtask

    // Start a scan, run it to done (bounded), log accepted entries and
    // verify that stalled entries hold still. pat[cyc mod 4] drives out_ready.
    task automatic run_scan(input logic [1:0] s, input logic [15:0] f, input logic [3:0] pat);
        logic [3:0] hold_pin;
        logic [2:0] hold_code;
        logic       stalled;
        int         cyc;
        bus.sel = s; bus.func = f; bus.start = 1'b1; bus.out_ready = pat[0];
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 1; n_ent = 0; n_valid = 0; done_cyc = -1; stalled = 1'b0;
        hold_pin = '0; hold_code = '0;
        err_c1 = bus.err;
        while (done_cyc < 0 && cyc < 200) begin
            if (cyc == poke_cyc) begin
                bus.start = 1'b1; bus.sel = 2'b11; bus.func = 16'hFFFF;
            end else begin
                bus.start = 1'b0;
            end
            bus.out_ready = pat[cyc[1:0]];
            if (stalled) begin
                check("stall_pin", 32'(bus.out_pin), 32'(hold_pin));
                check("stall_code", 32'(bus.out_code), 32'(hold_code));
            end
            stalled = 1'b0;
            if (bus.out_valid) begin
                n_valid++;
                if (bus.out_ready) begin
                    if (n_ent < 16) begin
                        ent_pin[n_ent]  = bus.out_pin;
                        ent_code[n_ent] = bus.out_code;
                    end
                    n_ent++;
                end else begin
                    stalled = 1'b1; hold_pin = bus.out_pin; hold_code = bus.out_code;
                end
            end
            if (bus.done) done_cyc = cyc;
            @(posedge clk); #1;
            cyc++;
        end
        bus.start = 1'b0;
        if (done_cyc < 0) check("scan_timeout", 0, 1);
    endtask

    initial begin
        logic [2:0] exp3 [6];
        rst_n = 1'b0; bus.start = 1'b0; bus.sel = '0; bus.func = '0; bus.out_ready = 1'b0;
        poke_cyc = -1;
        #12;
        check_all_zero("reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Test 1: u41 full scan, every pin on wire 0.
        run_scan(2'b10, 16'h1234, 4'b1111);
        check("t1_entries", n_ent, 10);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("t1_pin%0d", i), 32'(ent_pin[i]), i);
            check($sformatf("t1_code%0d", i), 32'(ent_code[i]), 0);
        end
        check("t1_done_cyc", done_cyc, 21);
        check("t1_count", 32'(bus.count), 10);
        check("t1_err", 32'(bus.err), 0);
        check("t1_busy_after", 32'(bus.busy), 0);

        // Test 2: invalid u21 function, started back-to-back.
        run_scan(2'b00, 16'h0010, 4'b1111);
        check("t2_valid_cycles", n_valid, 0);
        check("t2_done_cyc", done_cyc, 2);
        check("t2_count", 32'(bus.count), 0);

        // Test 3: u31 with out_ready toggling 1-0-0-1.
        exp3 = '{3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        run_scan(2'b01, 16'h00A5, 4'b1001);
        check("t3_entries", n_ent, 6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t3_pin%0d", i), 32'(ent_pin[i]), i);
            check($sformatf("t3_code%0d", i), 32'(ent_code[i]), 32'(exp3[i]));
        end
        check("t3_count", 32'(bus.count), 6);
        check("t3_err", 32'(bus.err), 0);

        // Test 4: multi-hot response on pin 2.
        inject_multi = 1'b1;
        run_scan(2'b00, 16'h0003, 4'b1111);
        inject_multi = 1'b0;
        check("t4_entries", n_ent, 4);
        check("t4_code0", 32'(ent_code[0]), 3);
        check("t4_pin2", 32'(ent_pin[2]), 2);
        check("t4_code2", 32'(ent_code[2]), 7);
        check("t4_code3", 32'(ent_code[3]), 0);
        check("t4_err", 32'(bus.err), 1);

        // Test 5: start pulse with sel=11 during a u21 scan is ignored.
        poke_cyc = 3;
        run_scan(2'b00, 16'h0001, 4'b1111);
        poke_cyc = -1;
        check("t4_err_cleared", 32'(err_c1), 0);
        check("t5_entries", n_ent, 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("t5_code%0d", i), 32'(ent_code[i]), i + 1);
        check("t5_qsel", 32'(bus.q_sel), 0);
        check("t5_qfunc", 32'(bus.q_func), 32'h0001);
        check("t5_done_cyc", done_cyc, 9);

        // Test 6: asynchronous reset while pin 1 is pending.
        bus.sel = 2'b01; bus.func = 16'h00A5; bus.start = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("t6_pre_valid", 32'(bus.out_valid), 1);
        check("t6_pre_pin", 32'(bus.out_pin), 1);
        bus.out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_all_zero("t6_rst");
        repeat (2) begin
            @(posedge clk); #1;
            check("t6_no_done", 32'(bus.done), 0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_scan(2'b01, 16'h00A5, 4'b1111);
        check("t6_entries", n_ent, 6);
        check("t6_pin0", 32'(ent_pin[0]), 0);
        check("t6_code0", 32'(ent_code[0]), 5);
        check("t6_count", 32'(bus.count), 6);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
